ram_read_arbiter: RTL and testbench
===================================

// Module: ram_read_arbiter
// PURPOSE
//  Shares the single MIG read command port and read-data FIFO between two requesters.
//  Requester 0 is the VGA pixel fetch path and has fixed priority. Requester 1 is the
//  sprite/blit fetch path and has a starvation guard.
//  One burst in flight at a time; returned beats are routed to the requester that owns the burst.
//  Sits between the VGA RAM controller / sprite engine and the MIG user port, in the pixel clock domain.
// PARAMETERS
//  ADDR_W        30  byte-address width of MIG cmd port
//  BL_W          6   burst-length field width (beats-1 encoding, as MIG)
//  DATA_W        32  read-data width
//  STARVE_LIMIT  8   consecutive req0 grants allowed while req1 is pending; next grant then goes to req1
// PORTS
//  Clk              in   1       single clock; all logic on posedge
//  Rst              in   1       asynchronous, active-high reset
//  calib_done       in   1       MIG calibration complete; no grant while low
//  r0_cmd_en        in   1       req0 burst request (level, held until ack)
//  r0_cmd_bl        in   BL_W    req0 burst length-1
//  r0_cmd_addr      in   ADDR_W  req0 byte address
//  r0_cmd_ack       out  1       one-cycle pulse: req0 request accepted
//  r0_rd_data       out  DATA_W  req0 returned beat
//  r0_rd_valid      out  1       req0 beat valid (one cycle per beat)
//  r1_*             -    -       identical set for requester 1
//  read_cmd_clk     out  1       = Clk
//  read_cmd_en      out  1       MIG command strobe
//  read_cmd_instr   out  3       constant 3'b001 (read)
//  read_cmd_bl      out  BL_W    latched burst length
//  read_cmd_byte_addr out ADDR_W latched address
//  read_cmd_full    in   1       MIG command FIFO full
//  rd_clk           out  1       = Clk
//  rd_en            out  1       pop MIG read FIFO
//  rd_data          in   DATA_W  MIG read data (first-word fall-through)
//  rd_empty         in   1       MIG read FIFO empty
//  rd_error         in   1       MIG read FIFO error
//  owner            out  1       requester owning current burst (valid when busy)
//  busy             out  1       state != IDLE
//  err              out  1       sticky; set on rd_error, cleared only by Rst
// BEHAVIOUR
//  Reset (async): state=IDLE; starve_cnt=0; beat_cnt=0; owner=0; err=0.
//    All outputs 0 except read_cmd_instr=3'b001 and the clock outputs.
//  Reset mid-burst abandons the burst; the MIG read FIFO must be reset alongside.
//  FSM states: IDLE -> ISSUE -> DRAIN -> IDLE.
//  IDLE, when calib_done and any rX_cmd_en:
//    - grant req1 if (r1 && !r0) or (r1 && starve_cnt==STARVE_LIMIT); else grant req0.
//    - latch bl/addr/owner; pulse that requester's ack in the next cycle; go ISSUE.
//  starve_cnt: +1 on each req0 grant while r1_cmd_en high (saturates at STARVE_LIMIT);
//    cleared on req1 grant or whenever r1_cmd_en is low in IDLE.
//  ISSUE: read_cmd_en = !read_cmd_full (combinational). On the cycle read_cmd_en=1:
//    beat_cnt = bl+1; go DRAIN. Held in ISSUE while read_cmd_full.
//  DRAIN: rd_en = !rd_empty (combinational).
//    - Each pop registers rd_data to the owner's rX_rd_data; owner's rX_rd_valid=1 next cycle.
//    - Non-owner rd_valid stays 0 and its rd_data holds its value.
//    - beat_cnt decrements per pop; the pop taking it to 0 returns the FSM to IDLE.
//    - New grant possible the cycle after the last pop.
//  Beat count is BL_W+1 bits wide (max 64 beats).
//  rd_error in any state sets err; the FSM continues (no recovery action).
//  Requester must hold en/bl/addr stable until ack; deasserting early is legal and cancels only if before grant.
//  Latency: en sampled in IDLE at edge N -> ack high cycle N+1 -> read_cmd_en earliest cycle N+1.
//    First rd_valid occurs one cycle after the first non-empty DRAIN cycle.
//  No rd_en outside DRAIN, even if rd_empty=0.
// TESTING
//  T1: req0 only, bl=15, addr=0x100 -> one ack; read_cmd_en=1 with bl=15, addr=0x100; 16 r0_rd_valid; r1_rd_valid never 1.
//  T2: r0 and r1 held high continuously, STARVE_LIMIT=8 -> grant sequence 8x req0, 1x req1, repeating.
//  T3: read_cmd_full high 5 cycles in ISSUE -> read_cmd_en stays 0, then exactly 1 pulse; bl/addr unchanged.
//  T4: rd_empty toggling every cycle during a 4-beat burst -> exactly 4 pops, 4 rd_valid; return to IDLE after 4th pop.
//  T5: calib_done=0 with r0 requesting -> no ack, no cmd_en; calib_done rises -> ack the following cycle.
//  T6: Rst pulsed mid-DRAIN (asynchronous, between edges) -> outputs 0 immediately; rd_error pulse afterwards sets err and holds it.

Source files
------------

// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: shares one MIG read command port and read-data FIFO between
// two requesters. Requester 0 (VGA pixel fetch) has fixed priority; requester 1
// (sprite/blit fetch) gets a grant after STARVE_LIMIT consecutive req0 grants
// while it waits. One burst is in flight at a time, and returned beats go to the
// requester that owns the burst.
//
// Ports:
//   Clk, Rst                          clock, asynchronous active-high reset
//   calib_done                        MIG calibration done; no grant while low
//   rX_cmd_en/bl/addr                 requester X burst request (level, held until ack)
//   rX_cmd_ack                        one-cycle pulse when requester X is accepted
//   rX_rd_data/rX_rd_valid            beats returned to requester X
//   read_cmd_*                        MIG command port (read_cmd_en is combinational)
//   rd_clk/rd_en/rd_data/rd_empty     MIG read FIFO (rd_en is combinational, FWFT data)
//   rd_error                          MIG read FIFO error
//   owner/busy/err                    status; err is sticky until reset
module ram_read_arbiter #(
    parameter int unsigned ADDR_W       = 30,
    parameter int unsigned BL_W         = 6,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              calib_done,
    input  logic              r0_cmd_en,
    input  logic [BL_W-1:0]   r0_cmd_bl,
    input  logic [ADDR_W-1:0] r0_cmd_addr,
    output logic              r0_cmd_ack,
    output logic [DATA_W-1:0] r0_rd_data,
    output logic              r0_rd_valid,
    input  logic              r1_cmd_en,
    input  logic [BL_W-1:0]   r1_cmd_bl,
    input  logic [ADDR_W-1:0] r1_cmd_addr,
    output logic              r1_cmd_ack,
    output logic [DATA_W-1:0] r1_rd_data,
    output logic              r1_rd_valid,
    output logic              read_cmd_clk,
    output logic              read_cmd_en,
    output logic [2:0]        read_cmd_instr,
    output logic [BL_W-1:0]   read_cmd_bl,
    output logic [ADDR_W-1:0] read_cmd_byte_addr,
    input  logic              read_cmd_full,
    output logic              rd_clk,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_empty,
    input  logic              rd_error,
    output logic              owner,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CNT_W = BL_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant, grant1;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              owner_q, owner_d;
    logic [BL_W-1:0]   bl_q, bl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              v0_q, v0_d, v1_q, v1_d;
    logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
    logic              err_q, err_d;
    logic              cmd_fire, pop;

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and grant decision
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        grant1  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (calib_done && (r0_cmd_en || r1_cmd_en)) begin
                    grant   = 1'b1;
                    // req1 wins when alone, or when req0 has used up its streak
                    grant1  = r1_cmd_en &&
                              (!r0_cmd_en || starve_q == STV_W'(STARVE_LIMIT));
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: if (!read_cmd_full) state_d = S_DRAIN;
            S_DRAIN: if (!rd_empty && beat_q == CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        cmd_fire = (state_q == S_ISSUE) && !read_cmd_full;
        pop      = (state_q == S_DRAIN) && !rd_empty;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        owner_d  = owner_q;
        bl_d     = bl_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        v0_d     = 1'b0;
        v1_d     = 1'b0;
        d0_d     = d0_q;
        d1_d     = d1_q;
        err_d    = err_q | rd_error;

        if (grant) begin
            owner_d = grant1;
            bl_d    = grant1 ? r1_cmd_bl   : r0_cmd_bl;
            addr_d  = grant1 ? r1_cmd_addr : r0_cmd_addr;
            ack0_d  = !grant1;
            ack1_d  = grant1;
        end

        // Starvation counter only moves while arbitrating
        if (state_q == S_IDLE) begin
            if (!r1_cmd_en || (grant && grant1)) begin
                starve_d = '0;
            end else if (grant && starve_q != STV_W'(STARVE_LIMIT)) begin
                starve_d = starve_q + STV_W'(1);
            end
        end

        if (cmd_fire) beat_d = {1'b0, bl_q} + CNT_W'(1);

        if (pop) begin
            beat_d = beat_q - CNT_W'(1);
            if (owner_q) begin
                v1_d = 1'b1;
                d1_d = rd_data;
            end else begin
                v0_d = 1'b0 | 1'b1;
                d0_d = rd_data;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            owner_q  <= 1'b0;
            bl_q     <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
            starve_q <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            d0_q     <= '0;
            d1_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            owner_q  <= owner_d;
            bl_q     <= bl_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            err_q    <= err_d;
        end
    end

    assign read_cmd_clk       = Clk;
    assign rd_clk             = Clk;
    assign read_cmd_instr     = 3'b001;
    assign read_cmd_en        = cmd_fire;
    assign rd_en              = pop;
    assign read_cmd_bl        = bl_q;
    assign read_cmd_byte_addr = addr_q;
    assign r0_cmd_ack         = ack0_q;
    assign r1_cmd_ack         = ack1_q;
    assign r0_rd_valid        = v0_q;
    assign r1_rd_valid        = v1_q;
    assign r0_rd_data         = d0_q;
    assign r1_rd_data         = d1_q;
    assign owner              = owner_q;
    assign busy               = (state_q != S_IDLE);
    assign err                = err_q;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Directed bench for ram_read_arbiter with a small FWFT MIG model and a beat scoreboard.
module tb_ram_read_arbiter;

    logic        Clk, Rst, calib_done;
    logic        r0_cmd_en, r1_cmd_en;
    logic [5:0]  r0_cmd_bl, r1_cmd_bl;
    logic [29:0] r0_cmd_addr, r1_cmd_addr;
    logic        r0_cmd_ack, r1_cmd_ack;
    logic [31:0] r0_rd_data, r1_rd_data;
    logic        r0_rd_valid, r1_rd_valid;
    logic        read_cmd_clk, read_cmd_en, read_cmd_full;
    logic [2:0]  read_cmd_instr;
    logic [5:0]  read_cmd_bl;
    logic [29:0] read_cmd_byte_addr;
    logic        rd_clk, rd_en, rd_empty, rd_error;
    logic [31:0] rd_data;
    logic        owner, busy, err;

    ram_read_arbiter dut (
        .Clk(Clk), .Rst(Rst), .calib_done(calib_done),
        .r0_cmd_en(r0_cmd_en), .r0_cmd_bl(r0_cmd_bl), .r0_cmd_addr(r0_cmd_addr),
        .r0_cmd_ack(r0_cmd_ack), .r0_rd_data(r0_rd_data), .r0_rd_valid(r0_rd_valid),
        .r1_cmd_en(r1_cmd_en), .r1_cmd_bl(r1_cmd_bl), .r1_cmd_addr(r1_cmd_addr),
        .r1_cmd_ack(r1_cmd_ack), .r1_rd_data(r1_rd_data), .r1_rd_valid(r1_rd_valid),
        .read_cmd_clk(read_cmd_clk), .read_cmd_en(read_cmd_en),
        .read_cmd_instr(read_cmd_instr), .read_cmd_bl(read_cmd_bl),
        .read_cmd_byte_addr(read_cmd_byte_addr), .read_cmd_full(read_cmd_full),
        .rd_clk(rd_clk), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .rd_error(rd_error), .owner(owner), .busy(busy), .err(err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        own;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mig_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0, cmd_cnt = 0, v0_cnt = 0, v1_cnt = 0, ack0_cnt = 0;
    bit          toggle_mode = 1'b0;
    bit          phase = 1'b0;

    function automatic logic [31:0] beat_word(input logic [29:0] addr, input int i);
        logic [15:0] lo;
        lo = addr[15:0];
        return {lo, 16'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input logic own, input logic [29:0] addr, input int beats);
        exp_t e;
        for (int i = 0; i < beats; i++) begin
            e.own  = own;
            e.data = beat_word(addr, i);
            sb.push_back(e);
        end
    endtask

    // Wait for the scoreboard to drain; the arbiter must already be idle then
    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_drain_in_time"}, 64'(sb.size() == 0), 64'(1));
        check({tag, "_idle_after_last"}, 64'(busy), 64'(0));
    endtask

    // MIG model bookkeeping: accept commands, pop the read FIFO
    always @(posedge Clk) begin
        if (Rst) begin
            mig_q.delete();
        end else begin
            if (rd_en) begin
                pop_cnt++;
                if (mig_q.size() > 0) void'(mig_q.pop_front());
            end
            if (read_cmd_en) begin
                cmd_cnt++;
                for (int i = 0; i <= int'(read_cmd_bl); i++)
                    mig_q.push_back(beat_word(read_cmd_byte_addr, i));
            end
        end
    end

    // MIG model read side: first-word fall-through, optional empty gaps
    always @(negedge Clk) begin
        phase = ~phase;
        if (mig_q.size() > 0 && !(toggle_mode && phase)) begin
            rd_empty = 1'b0;
            rd_data  = mig_q[0];
        end else begin
            rd_empty = 1'b1;
        end
    end

    // Beat monitor against the scoreboard
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (r0_cmd_ack) ack0_cnt++;
        if (r0_rd_valid || r1_rd_valid) begin
            check("valid_onehot", 64'(r0_rd_valid && r1_rd_valid), 64'(0));
            check("beat_expected", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("beat_owner", 64'(r1_rd_valid), 64'(e.own));
                check("beat_data", 64'(r1_rd_valid ? r1_rd_data : r0_rd_data), 64'(e.data));
            end
            if (r0_rd_valid) v0_cnt++;
            if (r1_rd_valid) v1_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_v0, base_v1, base_cmd, base_pop, base_ack0, acks, n;
        logic exp_own;

        Rst = 1'b0; calib_done = 1'b0;
        r0_cmd_en = 1'b0; r0_cmd_bl = '0; r0_cmd_addr = '0;
        r1_cmd_en = 1'b0; r1_cmd_bl = '0; r1_cmd_addr = '0;
        read_cmd_full = 1'b0; rd_error = 1'b0; rd_empty = 1'b1; rd_data = '0;
        #1 Rst = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_cmd_en", 64'(read_cmd_en), 64'(0));
        check("rst_rd_en", 64'(rd_en), 64'(0));
        check("rst_instr", 64'(read_cmd_instr), 64'(3'b001));
        check("rst_acks", 64'({r0_cmd_ack, r1_cmd_ack}), 64'(0));
        check("rst_valids", 64'({r0_rd_valid, r1_rd_valid}), 64'(0));
        check("rst_data", 64'({r0_rd_data, r1_rd_data}), 64'(0));
        check("rst_owner_err", 64'({owner, err}), 64'(0));
        check("rst_cmd_fields", 64'({read_cmd_bl, read_cmd_byte_addr}), 64'(0));
        check("clk_fwd", 64'({read_cmd_clk, rd_clk}), 64'({Clk, Clk}));
        @(negedge Clk);
        Rst = 1'b0;
        calib_done = 1'b1;

        // T1: single req0 burst of 16 beats
        @(negedge Clk);
        base_v0 = v0_cnt; base_v1 = v1_cnt; base_cmd = cmd_cnt; base_ack0 = ack0_cnt;
        r0_cmd_en = 1'b1; r0_cmd_bl = 6'd15; r0_cmd_addr = 30'h100;
        push_burst(1'b0, 30'h100, 16);
        @(negedge Clk);
        check("t1_ack0", 64'(r0_cmd_ack), 64'(1));
        check("t1_ack1", 64'(r1_cmd_ack), 64'(0));
        check("t1_cmd_en", 64'(read_cmd_en), 64'(1));
        check("t1_cmd_bl", 64'(read_cmd_bl), 64'(15));
        check("t1_cmd_addr", 64'(read_cmd_byte_addr), 64'(30'h100));
        check("t1_busy_owner", 64'({busy, owner}), 64'(2'b10));
        r0_cmd_en = 1'b0;
        wait_drain("t1", 200);
        check("t1_r0_beats", 64'(v0_cnt - base_v0), 64'(16));
        check("t1_r1_beats", 64'(v1_cnt - base_v1), 64'(0));
        check("t1_cmds", 64'(cmd_cnt - base_cmd), 64'(1));
        check("t1_one_ack", 64'(ack0_cnt - base_ack0), 64'(1));

        // T2: both requesters held high; 8 req0 grants then 1 req1 grant, twice
        r0_cmd_bl = 6'd0; r0_cmd_addr = 30'h1000;
        r1_cmd_bl = 6'd0; r1_cmd_addr = 30'h2000;
        for (int k = 0; k < 18; k++)
            push_burst(k % 9 == 8, (k % 9 == 8) ? 30'h2000 : 30'h1000, 1);
        r0_cmd_en = 1'b1; r1_cmd_en = 1'b1;
        acks = 0; n = 0;
        while (acks < 18 && n < 400) begin
            @(negedge Clk);
            n++;
            if (r0_cmd_ack || r1_cmd_ack) begin
                exp_own = (acks % 9 == 8);
                check($sformatf("t2_grant%0d", acks), 64'({r1_cmd_ack, r0_cmd_ack}),
                      64'({exp_own, !exp_own}));
                acks++;
                if (acks == 18) begin
                    r0_cmd_en = 1'b0; r1_cmd_en = 1'b0;
                end
            end
        end
        r0_cmd_en = 1'b0; r1_cmd_en = 1'b0;
        check("t2_grant_count", 64'(acks), 64'(18));
        wait_drain("t2", 100);

        // T3: command FIFO full for 5 cycles in ISSUE
        @(negedge Clk);
        base_cmd = cmd_cnt; base_v1 = v1_cnt;
        read_cmd_full = 1'b1;
        r1_cmd_en = 1'b1; r1_cmd_bl = 6'd3; r1_cmd_addr = 30'h2040;
        push_burst(1'b1, 30'h2040, 4);
        @(negedge Clk);
        check("t3_ack1", 64'(r1_cmd_ack), 64'(1));
        r1_cmd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge Clk);
            check($sformatf("t3_held%0d", i),
                  64'({read_cmd_en, read_cmd_bl, read_cmd_byte_addr}),
                  64'({1'b0, 6'd3, 30'h2040}));
        end
        @(negedge Clk);
        read_cmd_full = 1'b0;
        #1;
        check("t3_release", 64'({read_cmd_en, read_cmd_bl, read_cmd_byte_addr}),
              64'({1'b1, 6'd3, 30'h2040}));
        wait_drain("t3", 100);
        check("t3_one_cmd", 64'(cmd_cnt - base_cmd), 64'(1));
        check("t3_r1_beats", 64'(v1_cnt - base_v1), 64'(4));

        // T4: read FIFO empty every other cycle during a 4-beat burst
        @(negedge Clk);
        toggle_mode = 1'b1;
        base_pop = pop_cnt; base_v0 = v0_cnt;
        r0_cmd_en = 1'b1; r0_cmd_bl = 6'd3; r0_cmd_addr = 30'h300;
        push_burst(1'b0, 30'h300, 4);
        @(negedge Clk);
        check("t4_ack0", 64'(r0_cmd_ack), 64'(1));
        r0_cmd_en = 1'b0;
        wait_drain("t4", 100);
        check("t4_pops", 64'(pop_cnt - base_pop), 64'(4));
        check("t4_r0_beats", 64'(v0_cnt - base_v0), 64'(4));
        toggle_mode = 1'b0;

        // T5: no grant before calibration
        @(negedge Clk);
        calib_done = 1'b0;
        r0_cmd_en = 1'b1; r0_cmd_bl = 6'd0; r0_cmd_addr = 30'h400;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check($sformatf("t5_blocked%0d", i), 64'({r0_cmd_ack, read_cmd_en, busy}), 64'(0));
        end
        calib_done = 1'b1;
        push_burst(1'b0, 30'h400, 1);
        @(negedge Clk);
        check("t5_ack_after_calib", 64'(r0_cmd_ack), 64'(1));
        r0_cmd_en = 1'b0;
        wait_drain("t5", 100);

        // T6: asynchronous reset in the middle of a req1 burst, then sticky err
        @(negedge Clk);
        base_v1 = v1_cnt;
        r1_cmd_en = 1'b1; r1_cmd_bl = 6'd7; r1_cmd_addr = 30'h500;
        push_burst(1'b1, 30'h500, 8);
        @(negedge Clk);
        r1_cmd_en = 1'b0;
        n = 0;
        while (v1_cnt - base_v1 < 2 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("t6_mid_burst", 64'({busy, owner}), 64'(2'b11));
        #2 Rst = 1'b1;
        #1;
        check("t6_rst_state", 64'({busy, owner, read_cmd_en, rd_en}), 64'(0));
        check("t6_rst_r1", 64'({r1_rd_valid, r1_rd_data}), 64'(0));
        check("t6_rst_cmd", 64'({read_cmd_bl, read_cmd_byte_addr}), 64'(0));
        check("t6_rst_err", 64'(err), 64'(0));
        sb.delete();
        @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        rd_error = 1'b1;
        @(negedge Clk);
        rd_error = 1'b0;
        check("t6_err_set", 64'(err), 64'(1));
        repeat (5) @(negedge Clk);
        check("t6_err_sticky", 64'({err, busy}), 64'(2'b10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
